// File: rtl/table_update_stage_if.sv
// rtl/table_update_stage_if.sv - rule-update command channel (valid/ready) of the table update stage
interface table_update_stage_if #(
  parameter int INDEX_BIT_LEN   = 11,
  parameter int ENTRY_BIT_LEN   = 60,
  parameter int COMMAND_BIT_LEN = 2
);
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic [COMMAND_BIT_LEN-1:0] cmd_op;
  logic [2:0]                 cmd_group;
  logic [INDEX_BIT_LEN-1:0]   cmd_index;
  logic [ENTRY_BIT_LEN-1:0]   cmd_data;

  modport master (output cmd_valid, cmd_op, cmd_group, cmd_index, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_group, cmd_index, cmd_data, output cmd_ready);
endinterface

// File: rtl/table_update_stage.sv
// rtl/table_update_stage.sv - buffers rule-update commands and sequences writes into the six group tables
// Optional macro UPDATE_STATS_EN adds saturating done/err pulse counters.
module table_update_stage #(
  parameter int INDEX_BIT_LEN             = 11,
  parameter int ENTRY_BIT_LEN             = 60,
  parameter int COMMAND_BIT_LEN           = 2,
  parameter int FIFO_DEPTH                = 4,
  parameter int G0_TABLE_ENTRY_SIZE       = 1738,
  parameter int G1_TABLE_ENTRY_SIZE       = 154,
  parameter int G2_TABLE_ENTRY_SIZE       = 18,
  parameter int G3_TABLE_ENTRY_SIZE       = 0,
  parameter int G4_TABLE_ENTRY_SIZE       = 29,
  parameter int G4_OTHER_TABLE_ENTRY_SIZE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  table_update_stage_if.slave        cmd,
  input  logic                       search_hold,
  output logic [5:0]                 tbl_we,
  output logic [5:0]                 tbl_re,
  output logic [INDEX_BIT_LEN-1:0]   tbl_addr,
  output logic [ENTRY_BIT_LEN-1:0]   tbl_din,
  input  logic [6*ENTRY_BIT_LEN-1:0] tbl_rdata,
  output logic                       upd_done,
  output logic                       upd_err
`ifdef UPDATE_STATS_EN
  ,
  output logic [15:0]                stat_done_cnt,
  output logic [15:0]                stat_err_cnt
`endif
);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = AW + 1;
  localparam int REC_W    = COMMAND_BIT_LEN + 3 + INDEX_BIT_LEN + ENTRY_BIT_LEN;
  localparam int NEXT_LSB = ENTRY_BIT_LEN - 1 - 2 * INDEX_BIT_LEN;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [COMMAND_BIT_LEN-1:0] OP_NOP    = COMMAND_BIT_LEN'(0);
  localparam logic [COMMAND_BIT_LEN-1:0] OP_INSERT = COMMAND_BIT_LEN'(1);
  localparam logic [COMMAND_BIT_LEN-1:0] OP_DELETE = COMMAND_BIT_LEN'(2);

  typedef enum logic [2:0] {IDLE, CHECK, READ, RDWAIT, WRITE} state_t;
  state_t state;

  logic [REC_W-1:0]           fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]              wr_ptr, rd_ptr;
  logic [CW-1:0]              count;
  logic                       push, pop;
  logic [COMMAND_BIT_LEN-1:0] c_op;
  logic [2:0]                 c_group;
  logic [INDEX_BIT_LEN-1:0]   c_index;
  logic [ENTRY_BIT_LEN-1:0]   c_data;
  logic [ENTRY_BIT_LEN-1:0]   rd_entry;

  assign cmd.cmd_ready = (count != DEPTH_C);
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign pop           = (state == IDLE) && (count != '0);

  function automatic logic in_range(input logic [2:0] g, input logic [INDEX_BIT_LEN-1:0] idx);
    int unsigned sz;
    case (g)
      3'd0:    sz = G0_TABLE_ENTRY_SIZE;
      3'd1:    sz = G1_TABLE_ENTRY_SIZE;
      3'd2:    sz = G2_TABLE_ENTRY_SIZE;
      3'd3:    sz = G3_TABLE_ENTRY_SIZE;
      3'd4:    sz = G4_TABLE_ENTRY_SIZE;
      3'd5:    sz = G4_OTHER_TABLE_ENTRY_SIZE;
      default: sz = 0;
    endcase
    return 32'(idx) < sz;
  endfunction

  always_comb begin
    rd_entry = '0;
    for (int g = 0; g < 6; g++)
      if (c_group == 3'(g)) rd_entry = tbl_rdata[g*ENTRY_BIT_LEN +: ENTRY_BIT_LEN];
  end

  always_ff @(posedge clk)
    if (push) fifo_mem[wr_ptr] <= {cmd.cmd_op, cmd.cmd_group, cmd.cmd_index, cmd.cmd_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      c_op     <= '0;
      c_group  <= '0;
      c_index  <= '0;
      c_data   <= '0;
      tbl_we   <= '0;
      tbl_re   <= '0;
      tbl_addr <= '0;
      tbl_din  <= '0;
      upd_done <= 1'b0;
      upd_err  <= 1'b0;
    end else begin
      tbl_we   <= '0;
      tbl_re   <= '0;
      upd_done <= 1'b0;
      upd_err  <= 1'b0;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);

      case (state)
        IDLE: if (pop) begin
          {c_op, c_group, c_index, c_data} <= fifo_mem[rd_ptr];
          state <= CHECK;
        end
        CHECK: begin
          tbl_addr <= c_index;
          if (c_op == OP_NOP) begin
            upd_done <= 1'b1;
            state    <= IDLE;
          end else if (!in_range(c_group, c_index)) begin
            upd_err <= 1'b1;
            state   <= IDLE;
          end else if (c_op == OP_INSERT) begin
            tbl_din <= {1'b1, c_data[ENTRY_BIT_LEN-2:0]};
            state   <= WRITE;
          end else if (c_op == OP_DELETE) begin
            tbl_din <= '0;
            state   <= WRITE;
          end else begin
            state <= READ;
          end
        end
        READ: if (!search_hold) begin
          tbl_re <= 6'b000001 << c_group;
          state  <= RDWAIT;
        end
        RDWAIT: begin
          // A MODIFY_NEXT on an empty slot would fabricate a rule, so it is refused.
          if (!rd_entry[ENTRY_BIT_LEN-1]) begin
            upd_err <= 1'b1;
            state   <= IDLE;
          end else begin
            tbl_din <= {rd_entry[ENTRY_BIT_LEN-1:NEXT_LSB+INDEX_BIT_LEN],
                        c_data[INDEX_BIT_LEN-1:0], rd_entry[NEXT_LSB-1:0]};
            state   <= WRITE;
          end
        end
        WRITE: if (!search_hold) begin
          tbl_we   <= 6'b000001 << c_group;
          upd_done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UPDATE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_done_cnt <= '0;
      stat_err_cnt  <= '0;
    end else begin
      if (upd_done && stat_done_cnt != 16'hFFFF) stat_done_cnt <= stat_done_cnt + 16'd1;
      if (upd_err && stat_err_cnt != 16'hFFFF)   stat_err_cnt  <= stat_err_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_table_update_stage.sv
// tb/tb_table_update_stage.sv - directed and randomized checks of table_update_stage against a command-level model
module tb_table_update_stage;
  localparam int IL = 11;
  localparam int EL = 60;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, search_hold, upd_done, upd_err;
  logic [5:0] tbl_we, tbl_re;
  logic [IL-1:0] tbl_addr;
  logic [EL-1:0] tbl_din;
  logic [6*EL-1:0] tbl_rdata;
`ifdef UPDATE_STATS_EN
  logic [15:0] stat_done_cnt, stat_err_cnt;
`endif

  table_update_stage_if #(.INDEX_BIT_LEN(IL), .ENTRY_BIT_LEN(EL), .COMMAND_BIT_LEN(2)) cmd ();

  table_update_stage dut (
    .clk(clk), .rst(rst), .cmd(cmd), .search_hold(search_hold),
    .tbl_we(tbl_we), .tbl_re(tbl_re), .tbl_addr(tbl_addr), .tbl_din(tbl_din),
    .tbl_rdata(tbl_rdata), .upd_done(upd_done), .upd_err(upd_err)
`ifdef UPDATE_STATS_EN
    , .stat_done_cnt(stat_done_cnt), .stat_err_cnt(stat_err_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int sz [8] = '{1738, 154, 18, 0, 29, 0, 0, 0};
  bit rand_hold = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Untouched table contents: a mix of valid and empty slots.
  function automatic logic [EL-1:0] init_entry(input int g, input int a);
    logic [IL-1:0] ai;
    ai = IL'(a);
    return {(a % 3) != 0, ai, ai ^ 11'h555, 37'(a * 7919 + g * 131)};
  endfunction

  // Physical tables driven by the DUT's write port.
  logic [EL-1:0] phys [6][2048];
  logic          phys_wr [6][2048];
  always @(posedge clk)
    for (int g = 0; g < 6; g++)
      if (tbl_we[g]) begin
        phys[g][tbl_addr]    <= tbl_din;
        phys_wr[g][tbl_addr] <= 1'b1;
      end

  always_comb
    for (int g = 0; g < 6; g++)
      tbl_rdata[g*EL +: EL] = (phys_wr[g][tbl_addr] === 1'b1) ? phys[g][tbl_addr]
                                                               : init_entry(g, int'(tbl_addr));

  // Edge-sampled view of the handshake, hold and reset.
  logic acc_q, rst_q, hold_q;
  logic [1:0] acc_op;
  logic [2:0] acc_g;
  logic [IL-1:0] acc_i;
  logic [EL-1:0] acc_d;
  always @(posedge clk) begin
    rst_q  <= rst;
    hold_q <= search_hold;
    acc_q  <= cmd.cmd_valid && cmd.cmd_ready && !rst;
    acc_op <= cmd.cmd_op;
    acc_g  <= cmd.cmd_group;
    acc_i  <= cmd.cmd_index;
    acc_d  <= cmd.cmd_data;
  end

  // Command-level model: accepted commands complete strictly in order against a model table.
  typedef struct packed {
    logic [1:0] op;
    logic [2:0] g;
    logic [IL-1:0] idx;
    logic [EL-1:0] d;
  } cmd_t;
  cmd_t q [$];
  logic [EL-1:0] model_mem [6][2048];
  logic          model_wr [6][2048];
  bit head_read = 0;

  always @(negedge clk) begin
    cmd_t c;
    int kind;
    bit ok_range;
    logic [EL-1:0] cur, exp_d;
    kind = 0; ok_range = 0; cur = '0; exp_d = '0; c = '0;
    if (q.size() != 0) begin
      c = q[0];
      ok_range = (c.g < 6) && (int'(c.idx) < sz[c.g]);
      if (c.g < 6)
        cur = (model_wr[c.g][c.idx] === 1'b1) ? model_mem[c.g][c.idx] : init_entry(int'(c.g), int'(c.idx));
      if (c.op == 2'd0) kind = 0;
      else if (!ok_range) kind = 1;
      else if (c.op == 2'd1) begin kind = 2; exp_d = c.d | (60'h1 << 59); end
      else if (c.op == 2'd2) begin kind = 2; exp_d = '0; end
      else if (!cur[59]) kind = 1;
      else begin kind = 2; exp_d = {cur[59:48], c.d[10:0], cur[36:0]}; end
    end
    check("port_exclusive", ($countones(tbl_we) <= 1) && ($countones(tbl_re) <= 1)
                            && !(tbl_we != 0 && tbl_re != 0), 1);
    if (rst_q) begin
      q.delete();
      head_read = 0;
      check("reset_quiet", {tbl_we, tbl_re, upd_done, upd_err}, 0);
    end else begin
      if (hold_q) check("held_no_access", {tbl_we, tbl_re}, 0);
      if (tbl_re != 0) begin
        check("read_has_cmd", q.size() != 0, 1);
        if (q.size() != 0) begin
          check("read_group", tbl_re, 6'b000001 << c.g);
          check("read_addr", tbl_addr, c.idx);
          check("read_op", c.op, 2'd3);
          head_read = 1;
        end
      end
      if (tbl_we != 0 || upd_done || upd_err) begin
        check("event_has_cmd", q.size() != 0, 1);
        if (q.size() != 0) begin
          check("event_kind", {tbl_we != 0, upd_err, upd_done},
                kind == 2 ? 3'b101 : (kind == 1 ? 3'b010 : 3'b001));
          check("read_before_event", head_read, (c.op == 2'd3) && ok_range);
          if (kind == 2) begin
            check("write_group", tbl_we, 6'b000001 << c.g);
            check("write_addr", tbl_addr, c.idx);
            check("write_data", tbl_din, exp_d);
            model_mem[c.g][c.idx] = exp_d;
            model_wr[c.g][c.idx]  = 1'b1;
          end
          void'(q.pop_front());
          head_read = 0;
        end
      end
      if (acc_q) begin
        c.op = acc_op; c.g = acc_g; c.idx = acc_i; c.d = acc_d;
        q.push_back(c);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (rand_hold) search_hold = ($urandom_range(0, 3) == 0);
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] g, input logic [IL-1:0] idx,
                      input logic [EL-1:0] d);
    int n;
    n = 0;
    cmd.cmd_valid = 1'b1;
    cmd.cmd_op = op; cmd.cmd_group = g; cmd.cmd_index = idx; cmd.cmd_data = d;
    while (!cmd.cmd_ready && n < 500) begin step(); n++; end
    check("accept_wait", n < 500, 1);
    step();
    cmd.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    step();
    while (q.size() != 0 && n < 400) begin step(); n++; end
    check("drain", q.size(), 0);
    step();
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_g0, seen_err, seen_g2;
    int n;
    rst = 1'b1; search_hold = 1'b0;
    cmd.cmd_valid = 1'b0; cmd.cmd_op = '0; cmd.cmd_group = '0; cmd.cmd_index = '0; cmd.cmd_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_we", tbl_we, 0);
    check("rst_re", tbl_re, 0);
    check("rst_addr", tbl_addr, 0);
    check("rst_din", tbl_din, 0);
    check("rst_done_err", {upd_done, upd_err}, 0);
    check("rst_ready", cmd.cmd_ready, 1);
    rst = 1'b0;

    // INSERT G1 idx 5: write in the cycle after edge N+3.
    send(2'd1, 3'd1, 11'd5, 60'h0123456789ABCD);
    step(); check("ins_lat_n1", tbl_we, 0);
    step(); check("ins_lat_n2", tbl_we, 0);
    step();
    check("ins_we", tbl_we, 6'b000010);
    check("ins_addr", tbl_addr, 11'd5);
    check("ins_din", tbl_din, 60'h80123456789ABCD);
    check("ins_done", upd_done, 1);
    drain();

    // DELETE at the last G0 slot, then INSERT one past the end of G2.
    send(2'd2, 3'd0, 11'd1737, 60'h0);
    send(2'd1, 3'd2, 11'd18, 60'h123);
    seen_g0 = 0; seen_err = 0; seen_g2 = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (tbl_we[0]) begin
        seen_g0 = 1;
        check("del_addr", tbl_addr, 11'd1737);
        check("del_din", tbl_din, 0);
      end
      if (tbl_we[2]) seen_g2 = 1;
      if (upd_err) seen_err = 1;
    end
    check("del_seen", seen_g0, 1);
    check("g2_oob_err", seen_err, 1);
    check("g2_oob_no_write", seen_g2, 0);
    drain();

    // MODIFY_NEXT on a freshly inserted G4 entry.
    send(2'd1, 3'd4, 11'd3, {1'b0, 11'h07B, 11'h000, 37'h0_0ABC_DEF1});
    drain();
    send(2'd3, 3'd4, 11'd3, 60'h2A);
    step(); check("mod_lat_n1", tbl_re, 0);
    step(); check("mod_lat_n2", tbl_re, 0);
    step();
    check("mod_re", tbl_re, 6'b010000);
    check("mod_re_addr", tbl_addr, 11'd3);
    step(); check("mod_lat_n4", tbl_we, 0);
    step();
    check("mod_we", tbl_we, 6'b010000);
    check("mod_din", tbl_din, {1'b1, 11'h07B, 11'h02A, 37'h0_0ABC_DEF1});
    drain();

    // Three held cycles over a pending write.
    send(2'd1, 3'd1, 11'd7, 60'h0AA555512345678);
    step(); step();
    search_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("held_we", tbl_we, 0);
      check("held_addr", tbl_addr, 11'd7);
      check("held_din", tbl_din, 60'h8AA555512345678);
    end
    search_hold = 1'b0;
    step();
    check("released_we", tbl_we, 6'b000010);
    drain();

    // Fill the FIFO behind a held write.
    search_hold = 1'b1;
    send(2'd1, 3'd0, 11'd100, 60'h5);
    repeat (4) step();
    cmd.cmd_valid = 1'b1;
    cmd.cmd_op = 2'd1; cmd.cmd_group = 3'd1;
    for (int i = 0; i < 4; i++) begin
      cmd.cmd_index = IL'(20 + i);
      cmd.cmd_data  = EL'(i + 1);
      check("fill_ready", cmd.cmd_ready, 1);
      step();
    end
    cmd.cmd_index = 11'd24; cmd.cmd_data = 60'h99;
    check("fill_full", cmd.cmd_ready, 0);
    repeat (3) step();
    check("full_stays", cmd.cmd_ready, 0);
    search_hold = 1'b0;
    n = 0;
    while (!cmd.cmd_ready && n < 50) begin step(); n++; end
    check("fifth_ready", cmd.cmd_ready, 1);
    step();
    cmd.cmd_valid = 1'b0;
    drain();

    // Reset while the FSM waits on read data; a queued INSERT must be dropped too.
    send(2'd3, 3'd4, 11'd3, 60'h155);
    send(2'd1, 3'd1, 11'd50, 60'h777);
    n = 0;
    while (tbl_re == 0 && n < 10) begin step(); n++; end
    check("rst_re_seen", tbl_re, 6'b010000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("post_rst_ready", cmd.cmd_ready, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_rst_quiet", {tbl_we, upd_done, upd_err}, 0);
    end

    // Randomized traffic with random search_hold.
    rand_hold = 1;
    for (int i = 0; i < 400; i++) begin
      logic [63:0] r;
      logic [2:0] g;
      logic [IL-1:0] idx;
      r = {$urandom, $urandom};
      g = 3'($urandom_range(0, 6));
      case ($urandom_range(0, 3))
        0:       idx = IL'(sz[g]);
        1:       idx = IL'(sz[g] - 1);
        2:       idx = IL'($urandom_range(0, 31));
        default: idx = IL'($urandom_range(0, 2047));
      endcase
      send(2'($urandom_range(0, 3)), g, idx, r[EL-1:0]);
      if ($urandom_range(0, 3) == 0) step();
    end
    rand_hold = 0;
    search_hold = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/table_update_stage.md
Name: table_update_stage

Overview:
- Write-side counterpart of the search stage. Accepts rule-update commands through a valid/ready handshake and buffers them in a small FIFO.
- Drives the write ports (din/we/address) of the six group tables: G0, G1, G2, G3, G4, G4_other. These ports are tied off on the search side.
- Supports insert, delete and read-modify-write of next_index.
- Sits beside the search pipeline. Yields to search traffic through a hold input.

Parameters:
- INDEX_BIT_LEN, 11, width of table index / ruleID / next_index
- ENTRY_BIT_LEN, 60, table entry width
- COMMAND_BIT_LEN, 2, command opcode width
- FIFO_DEPTH, 4, command buffer depth (power of 2, >=2)
- G0_TABLE_ENTRY_SIZE, 1738, valid index range of G0
- G1_TABLE_ENTRY_SIZE, 154, valid index range of G1
- G2_TABLE_ENTRY_SIZE, 18, valid index range of G2
- G3_TABLE_ENTRY_SIZE, 0, valid index range of G3
- G4_TABLE_ENTRY_SIZE, 29, valid index range of G4
- G4_OTHER_TABLE_ENTRY_SIZE, 0, valid index range of G4_other

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command FIFO not full
- cmd_op  in  COMMAND_BIT_LEN  00 NOP, 01 INSERT, 10 DELETE, 11 MODIFY_NEXT
- cmd_group  in  3  0..5 = G0,G1,G2,G3,G4,G4_other
- cmd_index  in  INDEX_BIT_LEN  target entry
- cmd_data  in  ENTRY_BIT_LEN  INSERT: full entry; MODIFY_NEXT: [INDEX_BIT_LEN-1:0] = new next_index
- search_hold  in  1  search owns tables this cycle; no table access issued
- tbl_we  out  6  one-hot write enable, bit g = group g
- tbl_re  out  6  one-hot read enable
- tbl_addr  out  INDEX_BIT_LEN  shared read/write address
- tbl_din  out  ENTRY_BIT_LEN  shared write data
- tbl_rdata  in  6*ENTRY_BIT_LEN  group g read data at [g*60 +: 60], valid the cycle after tbl_re
- upd_done  out  1  one-cycle pulse per completed command
- upd_err  out  1  one-cycle pulse per rejected command

Behaviour:
- Entry layout:
  - [59] valid
  - [58:48] ruleID
  - [47:37] next_index
  - [36:0] key
- Reset values: all outputs 0 except cmd_ready=1. Reset empties the FIFO and returns the FSM to IDLE. A read or write in flight is abandoned, with no done or err pulse.
- Handshake and FIFO:
  - A command is accepted at a rising edge with cmd_valid && cmd_ready.
  - cmd_ready = !full.
  - A push and a pop in the same cycle are both honoured, and the count is unchanged.
  - Command order is strictly preserved.
- FSM states: IDLE, CHECK, READ, RDWAIT, WRITE.
- IDLE: FIFO non-empty -> pop the head into a command register -> CHECK.
- CHECK decides the command, then returns to IDLE unless stated otherwise:
  - NOP: upd_done pulse.
  - Group > 5 or index >= that group's ENTRY_SIZE (size 0 rejects every index): upd_err pulse, no table access.
  - INSERT: -> WRITE, with tbl_din = cmd_data and bit 59 forced to 1.
  - DELETE: -> WRITE, with tbl_din = all zeros.
  - MODIFY_NEXT: -> READ.
- READ: if search_hold, stay. Otherwise assert tbl_re[g] and tbl_addr for one cycle, then -> RDWAIT.
- RDWAIT:
  - Capture tbl_rdata slice g.
  - Build the write data from the captured entry with [47:37] replaced by cmd_data[10:0]. All other bits are unchanged.
  - -> WRITE.
  - If the captured valid bit is 0: upd_err pulse, no write, -> IDLE.
- WRITE: if search_hold, stay with tbl_we low. Otherwise assert tbl_we[g], tbl_addr and tbl_din for exactly one cycle, with an upd_done pulse in the same cycle, then -> IDLE.
- Output timing: tbl_we, tbl_re, tbl_addr, tbl_din, upd_done and upd_err are all registered outputs. tbl_we and tbl_re are never both non-zero, and at most one bit of each is set.
- Latency, with no hold and an empty FIFO, command accepted at edge N:
  - INSERT/DELETE: write asserted in the cycle after edge N+3.
  - MODIFY_NEXT: read in the cycle after edge N+3, write in the cycle after edge N+5.
- search_hold only freezes READ and WRITE. Hold asserted in the same cycle the FSM would issue delays the access by one cycle per held cycle. Data and address remain stable throughout.
- The FIFO keeps accepting commands while the FSM is held, until full.

Optional Feature:
- Macro: UPDATE_STATS_EN.
- When defined:
  - Adds outputs stat_done_cnt (16 bit) and stat_err_cnt (16 bit).
  - These count upd_done and upd_err pulses, saturate at 16'hFFFF, and clear on rst.
- When undefined, these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset, then INSERT G1 idx 5 data 60'h0_123_456_789ABCD -> tbl_we=6'b000010, tbl_addr=5, tbl_din bit59=1, upd_done in the same cycle, 4 cycles after acceptance.
- DELETE G0 idx 1737, then INSERT G2 idx 18 -> first: G0 write of all zeros at 1737 with done; second: upd_err pulse, tbl_we never set for G2.
- MODIFY_NEXT G4 idx 3 new next 11'h2A, tbl_rdata slice 4 = valid entry with next 0 -> tbl_re[4], then tbl_we[4] with din[47:37]=11'h2A and other bits equal to the read data.
- Push 5 commands back-to-back with search_hold=1 -> cmd_ready falls after 4 accepted, with no table access. Release hold -> 4 writes in order, then the 5th accepted.
- search_hold pulses for 3 cycles during a pending WRITE -> write delayed exactly 3 cycles, addr/din stable.
- rst asserted while in RDWAIT -> no write, no done/err pulse, FIFO empty, cmd_ready=1 the next cycle.
